lsu: RTL and testbench
======================

# lsu

Load/store unit between the core datapath and the data bus. It consumes the decoded `dbus_re`/`dbus_we` control bits, the ALU-computed effective address, the store operand and `funct3`. It runs one bus transaction per memory instruction over a req/ack handshake, stalling the core until the transaction finishes. Load results come back sign- or zero-extended for the `DEST_REG_FROM_MEM` writeback path.

## Interface
- `TIMEOUT`, default 255: BUSY cycles allowed without `bus_ack` before a fault. 0 disables the timeout. Legal range is 0..65535.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `re` in 1: load request (cu `dbus_re`).
- `we` in 1: store request (cu `dbus_we`). If `re` and `we` are both high, `we` takes priority.
- `funct3` in 3: access size and signedness.
- `addr` in 32: effective byte address.
- `wdata` in 32: store operand (rs2).
- `stall` out 1: core must hold the current instruction.
- `done` out 1: one-cycle pulse; the access completed.
- `fault` out 1: one-cycle pulse; misaligned, illegal or timed-out access.
- `rdata` out 32: extended load data, valid while `done`=1, 0 otherwise.
- `bus_req` out 1: transaction request.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_ack` in 1: slave completion.
- `bus_rdata` in 32: read data, sampled when `bus_ack`=1.

## Operation
- States: IDLE, BUSY, DONE, ERR.
- **IDLE**
  - If `re|we`, decode and check the request:
    - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
    - Legal stores: 000 SB, 001 SH, 010 SW.
    - Any other `funct3` is illegal.
    - Halfword needs `addr[0]`=0; word needs `addr[1:0]`=0.
  - Legal and aligned: latch `bus_addr`, `bus_be`, `bus_wdata`, `bus_we`, `funct3` and `addr[1:0]`, then go to BUSY.
  - Illegal or misaligned: go to ERR. No bus activity.
- **BUSY**
  - `bus_req`=1 and the latched bus fields are held stable.
  - `bus_ack`=1: capture the extracted `bus_rdata` and go to DONE.
  - Else the counter increments. If `TIMEOUT`≠0 and the counter reaches `TIMEOUT`, go to ERR.
  - Ack in the same cycle the counter reaches the limit: ack wins.
- **DONE**: `done`=1, `rdata` valid (0 for stores). Requests are ignored. Next state is IDLE.
- **ERR**: `fault`=1, `rdata`=0. Next state is IDLE.
- `bus_ack` outside BUSY is ignored.
- `stall` = (IDLE & (`re|we`)) | BUSY. It is combinational and low in DONE and ERR, so the core advances at the end of the DONE or ERR cycle.
- Byte enables (lane = `addr[1:0]`):
  - Byte: `4'b0001 << lane`.
  - Half: `4'b0011 << lane`.
  - Word: `4'b1111`.
  - Loads drive the same enables with `bus_we`=0.
- Store data: byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word `wdata`.
- Load extraction: take the byte or half at lane×8 from `bus_rdata`, then sign-extend (LB/LH) or zero-extend (LBU/LHU). LW passes the word through.

## Timing
- Reset (asynchronous): state goes to IDLE and the counter clears. All registered outputs go to 0 immediately: `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `done`, `fault`, `rdata`.
- Reset during BUSY drops `bus_req` without waiting for `bus_ack`.
- Latency from request cycle (cycle 0) with ack in BUSY cycle k (k≥1): DONE at cycle k+1, `stall` high for cycles 0..k. Minimum is 3 cycles per memory instruction.
- Misaligned or illegal access: ERR at cycle 1, 2 cycles total, `bus_req` never asserted.
- Timeout: ERR in the cycle after the `TIMEOUT`-th unacked BUSY cycle. `bus_req` deasserts in the ERR cycle.
- Back-to-back: a new request is accepted in the IDLE cycle following DONE/ERR.

## Test plan
- LW at 0x100, ack on the 2nd BUSY cycle, `bus_rdata`=0xDEADBEEF:
  - Bus: `bus_addr`=0x100, `bus_be`=1111, `bus_we`=0.
  - `done` pulses with `rdata`=0xDEADBEEF.
  - `stall` high for 3 cycles.
- LB at 0x103 with `bus_rdata`=0x80123456 → `bus_be`=1000, `rdata`=0xFFFFFF80. LBU at the same address → `rdata`=0x00000080.
- SH at 0x202 with `wdata`=0x0000ABCD → `bus_addr`=0x200, `bus_be`=1100, `bus_wdata`=0xABCDABCD, `bus_we`=1, `done` pulses.
- Misaligned and illegal accesses:
  - LW at 0x102 → `fault` pulses in cycle 1, `bus_req` stays 0, `stall` high only in cycle 0.
  - `funct3`=011 load → same response.
- `TIMEOUT`=4, no ack → `bus_req` high exactly 4 cycles, then `fault` pulses and state returns to IDLE.
- `rst` asserted mid-BUSY → `bus_req`=0 and `stall`=0 (with `re`/`we` low) asynchronously. The next LW after release completes normally.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: one req/ack bus transaction per memory instruction.
// Loads are sign/zero-extended; stores are lane-replicated.
module lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone, StErr} state_e;

    localparam logic [16:0] Limit = 17'(TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lane_q, lane_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_legal;
    logic        req_aligned;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] rd_shift;
    logic [31:0] load_ext;
    logic [16:0] cnt_inc;

    // Request decode; we has priority over re when both are set.
    always_comb begin
        if (we) begin
            req_legal = !funct3[2] && (funct3[1:0] != 2'b11);
        end else begin
            req_legal = (funct3[1:0] != 2'b11) && (funct3 != 3'b110);
        end
        req_aligned = 1'b1;
        req_be      = 4'b1111;
        req_wdata   = wdata;
        unique case (funct3[1:0])
            2'b00: begin
                req_be    = 4'b0001 << addr[1:0];
                req_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                req_aligned = !addr[0];
                req_be      = 4'b0011 << addr[1:0];
                req_wdata   = {2{wdata[15:0]}};
            end
            default: begin
                req_aligned = (addr[1:0] == 2'b00);
            end
        endcase
    end

    // Load extraction from the latched lane and access type.
    always_comb begin
        rd_shift = bus_rdata >> {lane_q, 3'b000};
        unique case (f3_q)
            3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  load_ext = {24'd0, rd_shift[7:0]};
            3'b101:  load_ext = {16'd0, rd_shift[15:0]};
            default: load_ext = bus_rdata;
        endcase
    end

    assign cnt_inc = {1'b0, cnt_q} + 17'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = 1'b0;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        f3_d        = f3_q;
        lane_d      = lane_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        rdata_d     = 32'd0;
        unique case (state_q)
            StIdle: begin
                if (re || we) begin
                    if (req_legal && req_aligned) begin
                        state_d     = StBusy;
                        cnt_d       = 16'd0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = we;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = req_be;
                        bus_wdata_d = req_wdata;
                        f3_d        = funct3;
                        lane_d      = addr[1:0];
                    end else begin
                        state_d = StErr;
                        fault_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (bus_ack) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    rdata_d = bus_we_q ? 32'd0 : load_ext;
                end else begin
                    cnt_d = cnt_inc[15:0];
                    if ((Limit != 17'd0) && (cnt_inc == Limit)) begin
                        state_d = StErr;
                        fault_d = 1'b1;
                    end else begin
                        bus_req_d = 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_wdata_q <= 32'd0;
            f3_q        <= 3'd0;
            lane_q      <= 2'd0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            f3_q        <= f3_d;
            lane_q      <= lane_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            rdata_q     <= rdata_d;
        end
    end

    assign stall     = ((state_q == StIdle) && (re || we)) || (state_q == StBusy);
    assign done      = done_q;
    assign fault     = fault_q;
    assign rdata     = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: driver pushes expected results from a byte-level
// model; a negedge monitor checks bus fields, pulses, and cycle counts.
module tb_lsu;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        re, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, fault;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          flt;
        logic [31:0] rdata;
        bit          st;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          busy;
        int          stalls;
    } exp_t;

    exp_t q[$];

    lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .re(re), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .stall(stall), .done(done), .fault(fault), .rdata(rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Byte-level reference: k is the BUSY cycle carrying the ack (>TO = none).
    function automatic exp_t model(bit w, logic [2:0] f3, logic [31:0] a,
                                   logic [31:0] wd, int k, logic [31:0] brd);
        exp_t e;
        int n, lane;
        logic [63:0] v;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
        lane = int'(a % 4);
        e.st = w;
        e.addr = a - 32'(lane);
        e.be = '0;
        e.wd = '0;
        e.rdata = '0;
        if (n == 0 || (w && f3[2]) || (!w && f3[2] && n == 4) || (a % n) != 0) begin
            e.flt = 1; e.busy = 0; e.stalls = 1;
            return e;
        end
        for (int i = 0; i < 4; i++) begin
            e.be[i] = (i >= lane && i < lane + n);
            e.wd[8*i +: 8] = wd[8*(i % n) +: 8];
        end
        v = {32'd0, brd} >> (8 * lane);
        if (n < 4) begin
            v = v & ((64'd1 << (8 * n)) - 64'd1);
            if (!f3[2] && v[8*n-1]) v = v - (64'd1 << (8 * n));
        end
        if (k > int'(TO)) begin
            e.flt = 1; e.busy = TO; e.stalls = TO + 1;
        end else begin
            e.flt = 0; e.busy = k; e.stalls = k + 1;
            e.rdata = w ? 32'd0 : v[31:0];
        end
        return e;
    endfunction

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the next IDLE cycle.
    task automatic txn(bit r, bit w, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                       int k, logic [31:0] brd, bit noise);
        exp_t e;
        e = model(w, f3, a, wd, k, brd);
        q.push_back(e);
        re = r; we = w; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk); #1;
        re = 0; we = 0; funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        if (e.busy > 0) begin
            for (int c = 1; c <= int'(TO) + 1; c++) begin
                if (c == k) begin bus_ack = 1; bus_rdata = brd; end
                @(posedge clk); #1;
                bus_ack = 0; bus_rdata = $urandom;
                if (c == k || c == int'(TO)) break;
            end
        end
        if (noise) begin
            re = 1'($urandom); we = 1'($urandom); bus_ack = 1;
        end
        @(posedge clk); #1;
        re = 0; we = 0; bus_ack = 0;
    endtask

    int busy_n = 0, stall_n = 0;

    always @(negedge clk) begin
        if (rst) begin
            busy_n  = 0;
            stall_n = 0;
        end else begin
            if (stall) stall_n++;
            if (bus_req) begin
                busy_n++;
                if (q.size() == 0) begin
                    chk("unexpected_bus_req", 32'(bus_req), 32'd0);
                end else begin
                    chk("bus_we", 32'(bus_we), 32'(q[0].st));
                    chk("bus_addr", bus_addr, q[0].addr);
                    chk("bus_be", 32'(bus_be), 32'(q[0].be));
                    if (q[0].st) chk("bus_wdata", bus_wdata, q[0].wd);
                end
            end
            if (!done) chk("rdata_idle_zero", rdata, 32'd0);
            if (done || fault) begin
                chk("done_fault_excl", 32'(done & fault), 32'd0);
                if (q.size() == 0) begin
                    chk("unexpected_completion", 32'(done | fault), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("fault", 32'(fault), 32'(e.flt));
                    if (done) chk("rdata", rdata, e.rdata);
                    chk("bus_req_cycles", 32'(busy_n), 32'(e.busy));
                    chk("stall_cycles", 32'(stall_n), 32'(e.stalls));
                end
                busy_n  = 0;
                stall_n = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; re = 0; we = 0; funct3 = 0; addr = 0; wdata = 0;
        bus_ack = 0; bus_rdata = 0;
        #3;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_outs", {bus_addr | bus_wdata | rdata}, 32'd0);
        chk("rst_bits", 32'({bus_we, bus_be, done, fault}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;

        txn(1, 0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF, 0);
        txn(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80123456, 0);
        txn(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80123456, 1);
        txn(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 1, 32'h0, 0);
        txn(1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h0, 0);
        txn(1, 0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 1);
        txn(1, 0, 3'b010, 32'h400, 32'h0, 99, 32'h0, 0);
        txn(1, 0, 3'b101, 32'h402, 32'h0, 4, 32'h9ABC1234, 0);
        txn(1, 1, 3'b000, 32'h501, 32'h000000A5, 3, 32'hFFFFFFFF, 1);

        // Reset while BUSY; the pending expectation is discarded.
        q.push_back(model(0, 3'b010, 32'h300, 32'h0, 99, 32'h0));
        re = 1; funct3 = 3'b010; addr = 32'h300;
        @(posedge clk); #1 re = 0;
        @(posedge clk); #1;
        #1 rst = 1;
        #1;
        chk("rst_busy_bus_req", 32'(bus_req), 32'd0);
        chk("rst_busy_stall", 32'(stall), 32'd0);
        q.delete();
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;
        txn(1, 0, 3'b010, 32'h300, 32'h0, 1, 32'h13572468, 0);

        for (int i = 0; i < 150; i++) begin
            int op;
            op = $urandom_range(0, 2);
            txn(op != 1, op != 0, 3'($urandom), $urandom, $urandom,
                $urandom_range(1, TO + 1), $urandom, 1'($urandom));
        end

        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
